uart_tx_ctrl: RTL

UART transmit controller that drains the transmit FIFO and serialises each byte onto the TX line as a standard asynchronous frame: start bit, DBIT data bits LSB first, stop bit(s). It sits directly downstream of the TX FIFO. It pops a word whenever the FIFO is non-empty and the line is idle, using the FIFO's head-of-queue `r_data`, `empty` and `rd` signals. It contains its own baud divider (16x oversampling tick), so no external tick is required.

---
 rtl/uart_tx_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops bytes from the TX FIFO and sends each one as
// start bit, DBIT data bits (LSB first) and stop bit(s), using its own 16x baud divider.
module uart_tx_ctrl #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int BW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [BW-1:0] B_LAST    = BW'(DVSR - 1);
    localparam logic [5:0]    S_LAST    = 6'd15;
    localparam logic [5:0]    S_STOP    = 6'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    state_t          state, state_n;
    logic [BW-1:0]   b, b_n;
    logic [5:0]      s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] sh, sh_n;
    logic            tx_n;
    logic            tick;

    assign tick    = (b == B_LAST);
    assign tx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            b     <= '0;
            s     <= '0;
            n     <= '0;
            sh    <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            b     <= b_n;
            s     <= s_n;
            n     <= n_n;
            sh    <= sh_n;
            tx    <= tx_n;
        end
    end

    always_comb begin
        state_n      = state;
        b_n          = b;
        s_n          = s;
        n_n          = n;
        sh_n         = sh;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;

        case (state)
            IDLE: begin
                b_n = '0;
                s_n = '0;
                // rst_n gate keeps the pop strobe quiet while reset is held
                if (!fifo_empty && rst_n) begin
                    fifo_rd = 1'b1;
                    sh_n    = fifo_data;
                    state_n = START;
                end
            end

            START: begin
                b_n = tick ? '0 : b + 1'b1;
                if (tick) begin
                    if (s == S_LAST) begin
                        s_n     = '0;
                        state_n = DATA;
                    end else begin
                        s_n = s + 6'd1;
                    end
                end
            end

            DATA: begin
                b_n = tick ? '0 : b + 1'b1;
                if (tick) begin
                    if (s == S_LAST) begin
                        s_n  = '0;
                        sh_n = sh >> 1;
                        if (n == N_LAST) begin
                            n_n     = '0;
                            state_n = STOP;
                        end else begin
                            n_n = n + 1'b1;
                        end
                    end else begin
                        s_n = s + 6'd1;
                    end
                end
            end

            STOP: begin
                b_n = tick ? '0 : b + 1'b1;
                if (tick) begin
                    if (s == S_STOP) begin
                        s_n          = '0;
                        tx_done_tick = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        s_n = s + 6'd1;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // tx is registered from the next-state view so the line changes on the same edge as the state
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = sh_n[0];
            default: tx_n = 1'b1;
        endcase
    end

endmodule
